// File: rtl/mmu.sv
// Purpose: two-level (4 KiB page) virtual-to-physical translating bridge between a CPU port and a memory bus.
// Latency: TLB hit = 1 bus access, miss = PDE + PTE + data accesses; v_ack_o pulses the cycle after the final ack_i.
// Backpressure: CPU request and bus request are level signals held until their acks; requests are ignored in COOL.
//
// Ports: clk/rst (sync, active-high); mmu_base_i/mmu_we/mmu_base_o page-directory base register;
//        v_* CPU side (address, write data, read data, rd/we request, ack);
//        addr_o/data_o/data_i/rd_o/we_o/ack_i bus side; page_fault pulse and page_fault_addr.
// Option: define MMU_TLB_EN to add a 4-entry fully associative TLB with round-robin replacement.
module mmu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmu_base_i,
    input  logic        mmu_we,
    output logic [31:0] mmu_base_o,
    input  logic [31:0] v_addr_i,
    input  logic [31:0] v_data_i,
    output logic [31:0] v_data_o,
    input  logic        v_we_i,
    input  logic        v_rd_i,
    output logic        v_ack_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        page_fault,
    output logic [31:0] page_fault_addr
);
    typedef enum logic [2:0] {S_IDLE, S_PDE, S_PTE, S_DATA, S_DONE, S_COOL} state_t;

    state_t      state, state_nxt;
    logic [31:0] base_r;
    logic [31:0] vaddr_r, wdata_r;
    logic        is_wr;
    logic [19:0] walk_base;   // base captured at request time so a mid-walk base write cannot redirect it
    logic [19:0] pde_ppn;
    logic [19:0] ppn_r;
    logic        req, bus_busy, bus_done, entry_bad;
    logic        issue, fault_now;
    logic [31:0] issue_addr;
    logic        tlb_hit;
    logic [19:0] tlb_hit_ppn;

    assign mmu_base_o = base_r;
    assign req        = v_rd_i | v_we_i;
    assign bus_busy   = rd_o | we_o;
    // an ack with no outstanding bus request is ignored
    assign bus_done   = bus_busy & ack_i;
    assign entry_bad  = ~data_i[0];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (req)      state_nxt = tlb_hit ? S_DATA : S_PDE;
            S_PDE:   if (bus_done) state_nxt = entry_bad ? S_COOL : S_PTE;
            S_PTE:   if (bus_done) state_nxt = entry_bad ? S_COOL : S_DATA;
            S_DATA:  if (bus_done) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_COOL;
            S_COOL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output decode: bus access issue (first cycle in a bus state) and fault detection
    always_comb begin
        issue      = 1'b0;
        fault_now  = 1'b0;
        issue_addr = '0;
        unique case (state)
            S_PDE: begin
                issue      = ~bus_busy;
                issue_addr = {walk_base, vaddr_r[31:22], 2'b00};
                fault_now  = bus_done & entry_bad;
            end
            S_PTE: begin
                issue      = ~bus_busy;
                issue_addr = {pde_ppn, vaddr_r[21:12], 2'b00};
                fault_now  = bus_done & entry_bad;
            end
            S_DATA: begin
                issue      = ~bus_busy;
                issue_addr = {ppn_r, vaddr_r[11:0]};
            end
            default: ;
        endcase
    end

    // registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r          <= '0;
            v_data_o        <= '0;
            v_ack_o         <= 1'b0;
            addr_o          <= '0;
            data_o          <= '0;
            rd_o            <= 1'b0;
            we_o            <= 1'b0;
            page_fault      <= 1'b0;
            page_fault_addr <= '0;
        end else begin
            v_ack_o    <= fault_now | (state == S_DATA && bus_done);
            page_fault <= fault_now;
            if (mmu_we) base_r <= mmu_base_i;
            if (issue) begin
                addr_o <= issue_addr;
                data_o <= wdata_r;
                we_o   <= (state == S_DATA) && is_wr;
                rd_o   <= !((state == S_DATA) && is_wr);
            end else if (bus_done) begin
                rd_o <= 1'b0;
                we_o <= 1'b0;
            end
            if (state == S_DATA && bus_done && !is_wr) v_data_o <= data_i;
            if (fault_now) page_fault_addr <= vaddr_r;
        end
    end

    // request capture and walk results
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            vaddr_r   <= v_addr_i;
            wdata_r   <= v_data_i;
            is_wr     <= v_we_i;           // write wins when both are requested
            walk_base <= base_r[31:12];
            ppn_r     <= tlb_hit_ppn;
        end
        if (state == S_PDE && bus_done) pde_ppn <= data_i[31:12];
        if (state == S_PTE && bus_done) ppn_r   <= data_i[31:12];
    end

`ifdef MMU_TLB_EN
    logic [3:0]  tlb_vld;
    logic [19:0] tlb_tag [4];
    logic [19:0] tlb_ppn [4];
    logic [1:0]  rr;
    logic        walk_ok;  // cleared by a base write so a stale walk never fills the TLB
    logic        tlb_ins;

    assign tlb_ins = (state == S_PTE) && bus_done && !entry_bad && walk_ok && !mmu_we;

    always_comb begin
        tlb_hit     = 1'b0;
        tlb_hit_ppn = '0;
        for (int i = 0; i < 4; i++) begin
            if (tlb_vld[i] && tlb_tag[i] == v_addr_i[31:12]) begin
                tlb_hit     = 1'b1;
                tlb_hit_ppn = tlb_ppn[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_vld <= '0;
            rr      <= '0;
            walk_ok <= 1'b0;
        end else begin
            if (state == S_IDLE && req) walk_ok <= 1'b1;
            if (tlb_ins) begin
                tlb_vld[rr] <= 1'b1;
                tlb_tag[rr] <= vaddr_r[31:12];
                tlb_ppn[rr] <= data_i[31:12];
                rr          <= rr + 2'd1;
            end
            // flush last so it overrides a same-cycle fill
            if (mmu_we) begin
                tlb_vld <= '0;
                walk_ok <= 1'b0;
            end
        end
    end
`else
    assign tlb_hit     = 1'b0;
    assign tlb_hit_ppn = '0;
`endif

endmodule

// File: tb/tb_mmu.sv
`timescale 1ns/1ps
module tb_mmu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mmu_base_i = '0;
    logic        mmu_we = 1'b0;
    logic [31:0] mmu_base_o;
    logic [31:0] v_addr_i = '0, v_data_i = '0;
    logic [31:0] v_data_o;
    logic        v_we_i = 1'b0, v_rd_i = 1'b0;
    logic        v_ack_o;
    logic [31:0] addr_o, data_o;
    logic [31:0] data_i = '0;
    logic        we_o, rd_o;
    logic        ack_i = 1'b0;
    logic        page_fault;
    logic [31:0] page_fault_addr;

    always #5 clk = ~clk;

    mmu dut (
        .clk(clk), .rst(rst), .mmu_base_i(mmu_base_i), .mmu_we(mmu_we), .mmu_base_o(mmu_base_o),
        .v_addr_i(v_addr_i), .v_data_i(v_data_i), .v_data_o(v_data_o), .v_we_i(v_we_i), .v_rd_i(v_rd_i),
        .v_ack_o(v_ack_o), .addr_o(addr_o), .data_i(data_i), .data_o(data_o), .we_o(we_o), .rd_o(rd_o),
        .ack_i(ack_i), .page_fault(page_fault), .page_fault_addr(page_fault_addr)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] dat; } acc_t;
    typedef struct { logic [19:0] vpn; logic [19:0] ppn; } tlbe_t;

    int     checks = 0, failures = 0;
    int     cyc = 0, ack_cyc = 0, stray_cnt = 0;
    acc_t   obs_q[$], exp_q[$];
    tlbe_t  tlb_q[$];
    logic [31:0] base_m = '0, last_rd = '0, last_pf = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0001_0001;
            32'h0001_0000: return 32'h0000_0001;
            32'h0001_0004: return 32'h0001_0001;
            32'h0001_0008: return 32'h0000_0000;
            default:       return a ^ 32'hC3A5_0F00;  // bit 0 clear for word addresses -> invalid entry
        endcase
    endfunction

    // bus responder: logs each access, checks it is held stable, acks 7 cycles after it appears
    initial begin
        int cnt = 0;
        int stray_seen = 0;
        logic busy = 1'b0;
        logic a_we = 1'b0;
        logic [31:0] a_addr = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            data_i = mem(addr_o);
            if (rst) begin
                busy  = 1'b0;
                ack_i = 1'b0;
            end else if (ack_i) begin
                ack_i = 1'b0;
            end else if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                ack_i = 1'b1;
            end else begin
                if (!busy && (rd_o || we_o)) begin
                    busy = 1'b1; cnt = 1; a_we = we_o; a_addr = addr_o;
                    obs_q.push_back('{we_o, addr_o, data_o});
                    chk1("bus_one_hot", rd_o & we_o, 1'b0);
                end else if (busy) begin
                    chk1("bus_req_held", rd_o | we_o, 1'b1);
                    chk1("bus_one_hot", rd_o & we_o, 1'b0);
                    chk1("bus_dir_stable", we_o, a_we);
                    chk("bus_addr_stable", addr_o, a_addr);
                    cnt++;
                end
                if (busy && cnt == 7) begin
                    ack_i = 1'b1; busy = 1'b0; ack_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_base"}, mmu_base_o, 32'h0);
        chk({tag, "_vdata"}, v_data_o, 32'h0);
        chk1({tag, "_vack"}, v_ack_o, 1'b0);
        chk({tag, "_addr"}, addr_o, 32'h0);
        chk({tag, "_data"}, data_o, 32'h0);
        chk1({tag, "_rd"}, rd_o, 1'b0);
        chk1({tag, "_we"}, we_o, 1'b0);
        chk1({tag, "_pf"}, page_fault, 1'b0);
        chk({tag, "_pfaddr"}, page_fault_addr, 32'h0);
    endtask

    task automatic quiet_window(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1({tag, "_rd"}, rd_o, 1'b0);
            chk1({tag, "_we"}, we_o, 1'b0);
            chk1({tag, "_vack"}, v_ack_o, 1'b0);
        end
    endtask

    task automatic set_base(input logic [31:0] b);
        @(negedge clk);
        mmu_base_i = b; mmu_we = 1'b1;
        @(negedge clk);
        mmu_we = 1'b0;
        base_m = b;
        tlb_q.delete();
        chk("base_reg", mmu_base_o, b);
    endtask

    // one CPU transaction; flush_at>0 pulses mmu_we (same base) that many cycles into the access
    task automatic do_txn(input logic wr, input logic [31:0] va, input logic [31:0] wd,
                          input int flush_at, output logic [31:0] rdat, output logic pf);
        logic hit = 1'b0, fault = 1'b0, got = 1'b0;
        logic [19:0] ppn = '0;
        logic [31:0] a, e;
        int n = 0;
        exp_q.delete();
        obs_q.delete();
`ifdef MMU_TLB_EN
        foreach (tlb_q[i]) if (tlb_q[i].vpn == va[31:12]) begin hit = 1'b1; ppn = tlb_q[i].ppn; end
`endif
        if (!hit) begin
            a = {base_m[31:12], va[31:22], 2'b00};
            exp_q.push_back('{1'b0, a, 32'h0});
            e = mem(a);
            if (!e[0]) fault = 1'b1;
            else begin
                a = {e[31:12], va[21:12], 2'b00};
                exp_q.push_back('{1'b0, a, 32'h0});
                e = mem(a);
                if (!e[0]) fault = 1'b1;
                else ppn = e[31:12];
            end
        end
        if (flush_at > 0) tlb_q.delete();
`ifdef MMU_TLB_EN
        else if (!hit && !fault) begin
            if (tlb_q.size() == 4) void'(tlb_q.pop_front());
            tlb_q.push_back('{va[31:12], ppn});
        end
`endif
        if (fault) last_pf = va;
        else begin
            a = {ppn, va[11:0]};
            exp_q.push_back('{wr, a, wr ? wd : 32'h0});
            if (!wr) last_rd = mem(a);
        end

        @(posedge clk); #1;
        v_addr_i = va; v_data_i = wd; v_we_i = wr;
        v_rd_i = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        while (n < 300 && !got) begin
            @(negedge clk);
            n++;
            if (flush_at > 0 && n == flush_at) begin mmu_base_i = base_m; mmu_we = 1'b1; end
            else mmu_we = 1'b0;
            if (v_ack_o) got = 1'b1;
        end
        rdat = v_data_o;
        pf   = page_fault;
        if (!got) chk1("vack_timeout", 1'b0, 1'b1);
        else begin
            chk1("page_fault", page_fault, fault);
            chk("page_fault_addr", page_fault_addr, last_pf);
            chk("v_data_o", v_data_o, last_rd);
            chk("vack_cycle_after_ack", cyc, ack_cyc);
        end
        @(posedge clk); #1;
        v_rd_i = 1'b0; v_we_i = 1'b0; mmu_we = 1'b0;
        @(negedge clk);
        chk1("vack_one_cycle", v_ack_o, 1'b0);
        chk1("pf_one_cycle", page_fault, 1'b0);
        chk("acc_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk("acc_addr", obs_q[i].addr, exp_q[i].addr);
            chk1("acc_we", obs_q[i].we, exp_q[i].we);
            if (exp_q[i].we) chk("acc_wdata", obs_q[i].dat, exp_q[i].dat);
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic pf;
        logic [31:0] va;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // stray ack with nothing outstanding
        stray_cnt++;
        quiet_window("stray", 12);

        set_base(32'h1234_5000);
        set_base(32'h0);

        // read v=0: PDE @0, PTE @0x10000, data @0
        do_txn(1'b0, 32'h0, 32'h0, 0, rd, pf);
        chk("r0_data", rd, 32'h0001_0001);
        chk("r0_pde", obs_q[0].addr, 32'h0);
        chk("r0_pte", obs_q[1].addr, 32'h0001_0000);
        chk("r0_phys", obs_q[2].addr, 32'h0);

        // page 1 maps to physical 0x10000
        do_txn(1'b0, 32'h1000, 32'h0, 0, rd, pf);
        chk("p1_phys", obs_q[2].addr, 32'h0001_0000);
        chk("p1_data", rd, 32'h0000_0001);
        for (int off = 4; off <= 32'h3C; off += 4) begin
            do_txn(1'b0, 32'h1000 + off, 32'h0, 0, rd, pf);
`ifdef MMU_TLB_EN
            chk("tlb_single_access", obs_q.size(), 1);
            chk("tlb_phys", obs_q[0].addr, 32'h0001_0000 + off);
`else
            chk("walk_phys", obs_q[2].addr, 32'h0001_0000 + off);
`endif
        end

        // write to page 2: invalid PTE -> fault, no data access
        do_txn(1'b1, 32'h2000, 32'hDEAD_BEEF, 0, rd, pf);
        chk1("fault_seen", pf, 1'b1);
        chk("fault_addr", page_fault_addr, 32'h0000_2000);
        chk("fault_accesses", obs_q.size(), 2);

        // base write flushes: full walk again
        set_base(32'h0);
        do_txn(1'b0, 32'h0, 32'h0, 0, rd, pf);
        chk("flush_walk_count", obs_q.size(), 3);
        chk("flush_walk_pde", obs_q[0].addr, 32'h0);

        // write v=0
        do_txn(1'b1, 32'h0, 32'h0123_4567, 0, rd, pf);
        chk1("wr_we", obs_q[obs_q.size()-1].we, 1'b1);
        chk("wr_addr", obs_q[obs_q.size()-1].addr, 32'h0);
        chk("wr_data", obs_q[obs_q.size()-1].dat, 32'h0123_4567);
        chk("wr_keeps_vdata", rd, 32'h0001_0001);

        // base write during a walk: walk completes but is not cached
        set_base(32'h0);
        do_txn(1'b0, 32'h1008, 32'h0, 3, rd, pf);
        do_txn(1'b0, 32'h100C, 32'h0, 0, rd, pf);
        chk("midwalk_no_fill", obs_q.size(), 3);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) set_base(32'h0);
            va = {($urandom_range(0, 7) == 0) ? 10'd1 : 10'd0, 10'($urandom_range(0, 3)),
                  10'($urandom_range(0, 1023)), 2'b00};
            do_txn(1'($urandom_range(0, 1)), va, $urandom, 0, rd, pf);
        end

        // reset in the middle of a bus access
        set_base(32'h0);
        @(posedge clk); #1;
        v_addr_i = 32'h1000; v_rd_i = 1'b1;
        repeat (4) @(negedge clk);
        chk1("pre_rst_rd", rd_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0; v_rd_i = 1'b0;
        base_m = '0; last_rd = '0; last_pf = '0; tlb_q.delete();
        stray_cnt++;
        quiet_window("post_rst", 12);
        do_txn(1'b0, 32'h1000, 32'h0, 0, rd, pf);
        chk("post_rst_walk", obs_q.size(), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmu.md
MMU -- requirements
Module: mmu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mmu_base_i  input  32  new page-directory base address.
REQ-005 mmu_we  input  1  write strobe for mmu_base_i.
REQ-006 mmu_base_o  output  32  current page-directory base.
REQ-007 v_addr_i  input  32  virtual address from the CPU side.
REQ-008 v_data_i  input  32  CPU write data.
REQ-009 v_data_o  output  32  CPU read data.
REQ-010 v_we_i / v_rd_i  input  1 each  CPU write / read request, level, held until v_ack_o.
REQ-011 v_ack_o  output  1  one-cycle completion pulse to the CPU.
REQ-012 addr_o  output  32  physical bus address.
REQ-013 data_i  input  32  bus read data.
REQ-014 data_o  output  32  bus write data.
REQ-015 we_o / rd_o  output  1 each  bus write / read request, level, held until ack_i.
REQ-016 ack_i  input  1  bus completion, sampled high on a rising edge.
REQ-017 page_fault  output  1  one-cycle translation-fault pulse.
REQ-018 page_fault_addr  output  32  faulting virtual address, held until the next fault.

Function
REQ-019 Translation SHALL be two-level with 4 KiB pages: PDE address = {base[31:12], v_addr[31:22], 2'b00}.
REQ-020 PTE address SHALL be {PDE[31:12], v_addr[21:12], 2'b00}.
REQ-021 Physical address SHALL be {PTE[31:12], v_addr[11:0]}.
REQ-022 Entry bit 0 SHALL mean valid; bits 11:1 SHALL be ignored.
REQ-023 States SHALL be IDLE, PDE, PTE, DATA, DONE and COOL.
REQ-024 IDLE SHALL sample the request; v_we_i SHALL win over v_rd_i when both are high.
REQ-025 On a TLB hit the block SHALL go to DATA; on a miss it SHALL go to PDE.
REQ-026 PDE and PTE SHALL assert rd_o with addr_o set to the entry address from the cycle after entry, and SHALL hold rd_o until ack_i.
REQ-027 When an entry with bit 0 = 0 is returned, the block SHALL pulse page_fault and v_ack_o together for one cycle.
REQ-028 On that fault it SHALL load page_fault_addr with v_addr_i, issue no data access, and go to COOL.
REQ-029 DATA SHALL drive the physical addr_o and assert rd_o, or assert we_o with data_o = v_data_i, until ack_i.
REQ-030 On a data-read ack the block SHALL latch data_i into v_data_o and hold it until the next completed read.
REQ-031 DONE SHALL pulse v_ack_o for exactly one cycle, starting the cycle after ack_i is sampled.
REQ-032 COOL SHALL ignore v_rd_i/v_we_i for exactly one cycle, then return to IDLE.
REQ-033 ack_i arriving while rd_o and we_o are both low SHALL be ignored.
REQ-034 rd_o and we_o SHALL never be high together.
REQ-035 addr_o, rd_o, we_o and data_o SHALL be registered outputs.
REQ-036 mmu_we SHALL load the base register the next edge and flush every TLB entry, in any state.
REQ-037 A walk in progress during mmu_we SHALL finish with its start-time base and SHALL NOT insert into the TLB.

Reset
REQ-038 On rst the block SHALL set state IDLE and clear all TLB valid bits.
REQ-039 On rst it SHALL clear mmu_base_o, v_data_o, v_ack_o, addr_o, data_o, rd_o, we_o, page_fault and page_fault_addr to 0.
REQ-040 Reset during a bus access SHALL abandon it and drop rd_o/we_o at that edge; a later ack_i SHALL be ignored.

Configuration
REQ-041 With MMU_TLB_EN defined, the block SHALL include a 4-entry fully associative TLB tagged by v_addr[31:12] and storing PTE[31:12].
REQ-042 The TLB SHALL be filled after a valid PTE, with round-robin replacement.
REQ-043 Without MMU_TLB_EN every access SHALL perform the full PDE/PTE walk, and the port list SHALL be unchanged.

Verification
Memory model for all scenarios: [0x0]=0x00010001, [0x10000]=0x00000001, [0x10004]=0x00010001, [0x10008]=0x00000000; the bench acks each bus access after 7 cycles.
REQ-044 Stray ack_i pulse after reset, no request -> no rd_o, we_o or v_ack_o.
REQ-045 mmu_we base=0, then read v=0x0 -> bus reads 0x0, 0x10000, 0x00000000 -> one v_ack_o pulse with v_data_o = returned data.
REQ-046 With MMU_TLB_EN, read 0x1000 then 0x1004..0x103C -> first access walks to physical 0x00010000; each later access is a single bus read at 0x000100xx.
REQ-047 Write v=0x2000 -> PTE read at 0x10008 returns 0 -> page_fault and v_ack_o pulse, page_fault_addr=0x00002000, no we_o.
REQ-048 mmu_we base=0 after TLB fill, then read 0x0 -> full walk repeated (PDE read at 0x0).
REQ-049 Write v=0x0 data 0x01234567 -> we_o at addr 0x00000000 with data_o=0x01234567 -> v_ack_o one cycle after ack_i.
